signed_addsub_pipe: RTL and testbench

SIGNED_ADDSUB_PIPE -- requirements
Module: signed_addsub_pipe

---
 rtl/signed_arith_pkg.sv | 28 ++
 rtl/signed_sat_wrap.sv | 42 ++++
 rtl/signed_addsub_pipe.sv | 165 ++++++++++++++++
 tb/tb_signed_addsub_pipe.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/signed_arith_pkg.sv
// -----------------------------------------------------------------------------
// signed_arith_pkg
// Shared definitions for the signed add/sub/accumulate pipeline:
//   - op_e          : operation encoding carried on the 2-bit `op` port
//   - sat_pos_limit : most-positive two's complement value for a given width
//   - sat_neg_limit : most-negative two's complement value for a given width
// The helpers return a 64-bit container; callers keep the low `width` bits.
// -----------------------------------------------------------------------------
package signed_arith_pkg;

    typedef enum logic [1:0] {
        OP_ADD  = 2'b00,
        OP_SUB  = 2'b01,
        OP_ACC  = 2'b10,
        OP_LOAD = 2'b11
    } op_e;

    // 2^(width-1)-1 : every bit below the sign bit set
    function automatic logic [63:0] sat_pos_limit(input int unsigned width);
        sat_pos_limit = (64'd1 << (width - 32'd1)) - 64'd1;
    endfunction

    // -2^(width-1) : only the sign bit set within the low `width` bits
    function automatic logic [63:0] sat_neg_limit(input int unsigned width);
        sat_neg_limit = 64'd1 << (width - 32'd1);
    endfunction

endpackage

// File: rtl/signed_sat_wrap.sv
// -----------------------------------------------------------------------------
// signed_sat_wrap
// Combinational overflow detect and saturate/wrap of a WIDTH+1-bit signed raw
// value down to WIDTH bits.
// Ports:
//   raw    in  WIDTH+1  sign-extended raw sum/difference
//   sat_en in  1        1 = clamp on overflow, 0 = wrap
//   result out WIDTH    final value
//   ovf    out 1        signed overflow (reported in both modes)
// -----------------------------------------------------------------------------
module signed_sat_wrap #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH:0]   raw,
    input  logic             sat_en,
    output logic [WIDTH-1:0] result,
    output logic             ovf
);
    import signed_arith_pkg::*;

    localparam logic [63:0]      POS_FULL = sat_pos_limit(WIDTH);
    localparam logic [63:0]      NEG_FULL = sat_neg_limit(WIDTH);
    localparam logic [WIDTH-1:0] POS_LIM  = POS_FULL[WIDTH-1:0];
    localparam logic [WIDTH-1:0] NEG_LIM  = NEG_FULL[WIDTH-1:0];

    // Overflow when the extra top bit disagrees with the WIDTH-bit sign bit;
    // raw[WIDTH] then holds the true sign and picks the clamp direction.
    always_comb begin
        ovf    = raw[WIDTH] ^ raw[WIDTH-1];
        result = raw[WIDTH-1:0];
        if (ovf && sat_en) begin
            if (raw[WIDTH]) begin
                result = NEG_LIM;
            end else begin
                result = POS_LIM;
            end
        end else begin
            result = raw[WIDTH-1:0];
        end
    end

endmodule

// File: rtl/signed_addsub_pipe.sv
// -----------------------------------------------------------------------------
// signed_addsub_pipe
// Two-stage valid/ready pipeline performing signed ADD, SUB, ACC (accumulate)
// and LOAD with selectable saturation or wrap on overflow.
//   S1 holds the WIDTH+1-bit raw value, S2 holds the final result and flag.
//   The accumulator is updated at input transfer so ACC ops chain with no
//   bubbles; the ACC/LOAD result leaving S2 equals that updated value.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   in_valid/ready  input handshake for a, b, op, sat_en
//   a, b            WIDTH-bit signed operands
//   op              00 ADD, 01 SUB, 10 ACC, 11 LOAD
//   sat_en          1 = saturate, 0 = wrap
//   out_valid/ready output handshake for result, ovf
//   result, ovf     final value and signed-overflow flag
//   acc_q           current accumulator value
// -----------------------------------------------------------------------------
module signed_addsub_pipe #(
    parameter int WIDTH       = 32,
    parameter bit SAT_DEFAULT = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [1:0]       op,
    input  logic             sat_en,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             ovf,
    output logic [WIDTH-1:0] acc_q
);
    import signed_arith_pkg::*;

    op_e              op_s;
    logic [WIDTH:0]   a_ext_s;
    logic [WIDTH:0]   b_ext_s;
    logic [WIDTH:0]   acc_ext_s;
    logic [WIDTH:0]   raw_s;
    logic             s2_adv_s;
    logic             s1_adv_s;
    logic             in_ready_s;
    logic             in_fire_s;
    logic [WIDTH-1:0] acc_final_s;
    logic             acc_ovf_s;
    logic [WIDTH-1:0] s2_result_s;
    logic             s2_ovf_raw_s;
    logic             s2_ovf_s;

    logic             s1_valid_r;
    logic [WIDTH:0]   s1_raw_r;
    op_e              s1_op_r;
    logic             s1_sat_r;
    logic             s1_acc_ovf_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] result_r;
    logic             ovf_r;
    logic [WIDTH-1:0] acc_r;

    assign op_s      = op_e'(op);
    assign a_ext_s   = {a[WIDTH-1], a};
    assign b_ext_s   = {b[WIDTH-1], b};
    assign acc_ext_s = {acc_r[WIDTH-1], acc_r};

    // Raw value at WIDTH+1 bits; subtraction is direct so b = min is exact.
    always_comb begin
        raw_s = a_ext_s;
        case (op_s)
            OP_ADD:  raw_s = a_ext_s + b_ext_s;
            OP_SUB:  raw_s = a_ext_s - b_ext_s;
            OP_ACC:  raw_s = acc_ext_s + a_ext_s;
            OP_LOAD: raw_s = a_ext_s;
            default: raw_s = a_ext_s;
        endcase
    end

    // Handshake: ready depends only on pipeline occupancy, out_ready and rst.
    always_comb begin
        s2_adv_s   = !out_valid_r || out_ready;
        s1_adv_s   = !s1_valid_r || s2_adv_s;
        in_ready_s = s1_adv_s && !rst;
        in_fire_s  = in_valid && in_ready_s;
    end

    // Accumulator path: final value computed from the same raw as S1 captures.
    signed_sat_wrap #(.WIDTH(WIDTH)) u_acc_sat (
        .raw    (raw_s),
        .sat_en (sat_en),
        .result (acc_final_s),
        .ovf    (acc_ovf_s)
    );

    // S2 path: resolve the raw value held in S1.
    signed_sat_wrap #(.WIDTH(WIDTH)) u_s2_sat (
        .raw    (s1_raw_r),
        .sat_en (s1_sat_r),
        .result (s2_result_s),
        .ovf    (s2_ovf_raw_s)
    );

    // ACC reuses the flag produced when acc_q was written; LOAD never overflows.
    always_comb begin
        s2_ovf_s = 1'b0;
        case (s1_op_r)
            OP_ADD:  s2_ovf_s = s2_ovf_raw_s;
            OP_SUB:  s2_ovf_s = s2_ovf_raw_s;
            OP_ACC:  s2_ovf_s = s1_acc_ovf_r;
            OP_LOAD: s2_ovf_s = 1'b0;
            default: s2_ovf_s = 1'b0;
        endcase
    end

    // S1 register: captures the raw value on input transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_r   <= 1'b0;
            s1_raw_r     <= '0;
            s1_op_r      <= OP_ADD;
            s1_sat_r     <= SAT_DEFAULT;
            s1_acc_ovf_r <= 1'b0;
        end else if (s1_adv_s) begin
            s1_valid_r <= in_fire_s;
            if (in_fire_s) begin
                s1_raw_r     <= raw_s;
                s1_op_r      <= op_s;
                s1_sat_r     <= sat_en;
                s1_acc_ovf_r <= (op_s == OP_ACC) ? acc_ovf_s : 1'b0;
            end
        end
    end

    // S2 register: result and flag; held unchanged while stalled.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_r <= 1'b0;
            result_r    <= '0;
            ovf_r       <= 1'b0;
        end else if (s2_adv_s) begin
            out_valid_r <= s1_valid_r;
            if (s1_valid_r) begin
                result_r <= s2_result_s;
                ovf_r    <= s2_ovf_s;
            end
        end
    end

    // Accumulator: written at input transfer of ACC or LOAD.
    always_ff @(posedge clk) begin
        if (rst) begin
            acc_r <= '0;
        end else if (in_fire_s && (op_s == OP_ACC || op_s == OP_LOAD)) begin
            acc_r <= acc_final_s;
        end
    end

    assign in_ready  = in_ready_s;
    assign out_valid = out_valid_r;
    assign result    = result_r;
    assign ovf       = ovf_r;
    assign acc_q     = acc_r;

endmodule

// File: tb/tb_signed_addsub_pipe.sv
module tb_signed_addsub_pipe;

    typedef struct {
        int res;
        int ovf;
        int xcyc;
        bit chk_lat;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [7:0] a = 8'd0;
    logic [7:0] b = 8'd0;
    logic [1:0] op = 2'd0;
    logic       sat_en = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] result;
    logic       ovf;
    logic [7:0] acc_q;

    exp_t sb[$];
    int   m_acc = 0;
    int   n_cmp = 0;
    int   n_err = 0;
    int   cyc = 0;
    bit   lat_mode = 1'b0;
    bit   toggle_ordy = 1'b0;
    bit   rand_ordy = 1'b0;

    signed_addsub_pipe #(.WIDTH(8), .SAT_DEFAULT(1'b0)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .sat_en    (sat_en),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .ovf       (ovf),
        .acc_q     (acc_q)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: exact integer arithmetic, then range check, clamp or wrap mod 256.
    task automatic model(input int o, input int x, input int y, input bit s, output exp_t e);
        int raw;
        case (o)
            0:       raw = x + y;
            1:       raw = x - y;
            2:       raw = m_acc + x;
            default: raw = x;
        endcase
        e.ovf = (raw > 127 || raw < -128) ? 1 : 0;
        if (raw > 127)       e.res = s ? 127 : raw - 256;
        else if (raw < -128) e.res = s ? -128 : raw + 256;
        else                 e.res = raw;
        if (o >= 2) m_acc = e.res;
    endtask

    // One cycle, entered at a negedge with inputs already set.
    task automatic do_cycle(output bit accepted);
        exp_t e;
        accepted = 1'b0;
        if (toggle_ordy)    out_ready = !out_ready;
        else if (rand_ordy) out_ready = ($urandom_range(3) != 0);
        #1;
        if (!rst) begin
            chk("in_ready", int'(in_ready), int'(sb.size() < 2 || out_ready));
            chk("acc_q", int'($signed(acc_q)), m_acc);
            if (in_valid && in_ready) begin
                model(int'(op), int'($signed(a)), int'($signed(b)), sat_en, e);
                e.xcyc    = cyc;
                e.chk_lat = lat_mode;
                sb.push_back(e);
                accepted = 1'b1;
            end
        end
        @(negedge clk);
    endtask

    task automatic issue(input int op_i, input int a_i, input int b_i, input bit sat_i);
        bit ok;
        ok = 1'b0;
        in_valid = 1'b1;
        op = op_i[1:0];
        a = a_i[7:0];
        b = b_i[7:0];
        sat_en = sat_i;
        for (int i = 0; i < 40 && !ok; i++) do_cycle(ok);
        if (!ok) chk("accept_timeout", int'(in_ready), 1);
        in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        bit d;
        in_valid = 1'b0;
        for (int i = 0; i < n; i++) do_cycle(d);
    endtask

    task automatic drain();
        bit d;
        toggle_ordy = 1'b0;
        rand_ordy = 1'b0;
        out_ready = 1'b1;
        in_valid = 1'b0;
        for (int i = 0; i < 20 && sb.size() > 0; i++) do_cycle(d);
        chk("drain_empty", sb.size(), 0);
    endtask

    // Monitor: pops the scoreboard on each output transfer, checks held outputs.
    bit   stalled = 1'b0;
    int   held_res = 0;
    int   held_ovf = 0;
    int   first_cyc = 0;
    exp_t me;
    always @(negedge clk) begin
        #2;
        if (rst) begin
            stalled = 1'b0;
        end else begin
            if (stalled) begin
                chk("hold_valid", int'(out_valid), 1);
                chk("hold_result", int'($signed(result)), held_res);
                chk("hold_ovf", int'(ovf), held_ovf);
            end
            if (out_valid && !stalled) first_cyc = cyc;
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("out_without_pending", int'(out_valid), 0);
                end else begin
                    me = sb.pop_front();
                    chk("result", int'($signed(result)), me.res);
                    chk("ovf", int'(ovf), me.ovf);
                    if (me.chk_lat) chk("latency", first_cyc - me.xcyc, 2);
                end
            end
            stalled  = out_valid && !out_ready;
            held_res = int'($signed(result));
            held_ovf = int'(ovf);
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        bit d;
        // Reset state
        rst = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_in_ready", int'(in_ready), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_result", int'(result), 0);
        chk("rst_ovf", int'(ovf), 0);
        chk("rst_acc_q", int'(acc_q), 0);
        rst = 1'b0;
        #1;
        chk("in_ready_after_rst", int'(in_ready), 1);
        @(negedge clk);

        // Directed corner cases with latency checking
        lat_mode = 1'b1;
        out_ready = 1'b1;
        issue(0, 100, 50, 1'b1);
        issue(0, 100, 50, 1'b0);
        issue(1, -128, 1, 1'b1);
        issue(1, 0, -128, 1'b1);
        issue(0, -5, 3, 1'b0);
        issue(1, 127, -128, 1'b0);
        // Back-to-back LOAD/ACC chain
        issue(3, 120, 0, 1'b1);
        issue(2, 5, 77, 1'b1);
        issue(2, 5, -9, 1'b1);
        drain();
        chk("acc_chain_final", int'($signed(acc_q)), 127);

        // Eight ADDs with out_ready toggling every cycle
        lat_mode = 1'b0;
        toggle_ordy = 1'b1;
        for (int i = 0; i < 8; i++)
            issue(0, int'($urandom_range(255)) - 128, int'($urandom_range(255)) - 128, 1'($urandom_range(1)));
        drain();

        // Reset with two operations in flight
        out_ready = 1'b0;
        issue(3, -100, 0, 1'b0);
        issue(2, -60, 0, 1'b1);
        in_valid = 1'b1;
        op = 2'b00;
        a = 8'd1;
        b = 8'd1;
        do_cycle(d);
        rst = 1'b1;
        in_valid = 1'b0;
        #1;
        chk("in_ready_during_rst", int'(in_ready), 0);
        @(negedge clk);
        chk("midrst_out_valid", int'(out_valid), 0);
        chk("midrst_acc_q", int'(acc_q), 0);
        sb.delete();
        m_acc = 0;
        rst = 1'b0;
        #1;
        chk("in_ready_after_midrst", int'(in_ready), 1);
        @(negedge clk);
        out_ready = 1'b1;
        idle(6);

        // Randomised mix with random backpressure and input gaps
        rand_ordy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(4) == 0)
                idle(1);
            else
                issue(int'($urandom_range(3)), int'($urandom_range(255)) - 128,
                      int'($urandom_range(255)) - 128, 1'($urandom_range(1)));
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
